unified_mem_arbiter: RTL and testbench

//  - Shares the single-ported unified instruction/data memory between the IF fetch port and the MEM-stage data port.
//  - Replaces the ad-hoc "data access steals the port" stall in the core with an explicit req/gnt handshake.
//  - Uses one registered command slot and a bounded data-priority scheme so fetch is never starved.
//  - Sits between the pipeline (IF stage, EX/MEM stage) and the Mem instance.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_streak_ctr.sv | 55 +++++
 rtl/unified_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory arbiter.
//   arb_state_t   - owner of the command slot (IDLE / IF_ACC / D_ACC)
//   FUNCT3_LW     - funct3 used for instruction fetches (full word)
//   SLOT_*_W      - field widths of the registered command slot
//   STREAK_W      - width of the consecutive-data-grant counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } arb_state_t;

  localparam logic [2:0] FUNCT3_LW = 3'b010;

  localparam int unsigned SLOT_FUNCT3_W = 3;
  localparam int unsigned SLOT_DATA_W   = 32;
  localparam int unsigned STREAK_W      = 4;

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// mem_arb_streak_ctr: priority decision between fetch and data requests plus
// the counter of consecutive data grants taken while a fetch is waiting.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   if_req, d_req     requests from the fetch and data ports
//   if_gnt, d_gnt     combinational grants (forced low while in reset)
//   streak            current consecutive-data-grant count
module mem_arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic                d_req,
  output logic                if_gnt,
  output logic                d_gnt,
  output logic [STREAK_W-1:0] streak
);

  localparam logic [STREAK_W-1:0] MAX_L = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  always_comb begin
    if_gnt   = 1'b0;
    d_gnt    = 1'b0;
    streak_d = streak_q;
    if (rst) begin
      // Data wins a tie until it has taken MAX_D_STREAK grants in a row.
      if (d_req && (!if_req || (streak_q < MAX_L))) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q < MAX_L)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign streak = streak_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares the single-ported unified memory between the
// IF fetch port and the MEM-stage data port via req/gnt handshakes.
// Grant in cycle N, memory driven from the command slot in N+1, response
// registered and rvalid pulsed in N+2 (one access per cycle throughput).
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   if_req/if_addr/if_gnt            fetch request side
//   if_rvalid/if_rdata               fetch response
//   d_req/d_we/d_funct3/d_addr/d_wdata/d_gnt   data request side
//   d_rvalid/d_rdata                 data response (rdata 0 for stores)
//   mem_read/mem_write/mem_funct3/mem_addr/mem_wdata/mem_rdata  to/from Mem
// Optional: define MEM_ARB_PERF_EN to add perf_if_wait / perf_d_grants.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_BASE    = 200,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_if_wait,
  output logic [31:0] perf_d_grants
`endif
);

  arb_state_t                 state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic                       we_q, we_d;
  logic [SLOT_FUNCT3_W-1:0]   funct3_q, funct3_d;
  logic [SLOT_DATA_W-1:0]     wdata_q, wdata_d;
  logic                       if_rvalid_q, if_rvalid_d;
  logic [31:0]                if_rdata_q, if_rdata_d;
  logic                       d_rvalid_q, d_rvalid_d;
  logic [31:0]                d_rdata_q, d_rdata_d;
  logic [STREAK_W-1:0]        streak_unused;
  logic                       addr_hi_unused;

  assign addr_hi_unused = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W], streak_unused};

  mem_arb_streak_ctr #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .d_req  (d_req),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt),
    .streak (streak_unused)
  );

  // Slot capture: whoever is granted this cycle owns the slot next cycle.
  always_comb begin
    state_d  = IDLE;
    addr_d   = addr_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    if (if_gnt) begin
      state_d  = IF_ACC;
      addr_d   = if_addr[ADDR_W-1:0];
      we_d     = 1'b0;
      funct3_d = FUNCT3_LW;
      wdata_d  = '0;
    end else if (d_gnt) begin
      state_d  = D_ACC;
      addr_d   = d_addr[ADDR_W-1:0];
      we_d     = d_we;
      funct3_d = d_funct3;
      wdata_d  = d_wdata;
    end
  end

  // Memory drive from the slot; decoded from the async-reset state so the
  // strobes drop the moment reset asserts.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IF_ACC: begin
        mem_read   = 1'b1;
        mem_funct3 = FUNCT3_LW;
        mem_addr   = 32'(addr_q);
      end
      D_ACC: begin
        mem_read   = !we_q;
        mem_write  = we_q;
        mem_funct3 = funct3_q;
        mem_addr   = 32'(addr_q) + 32'(DATA_BASE);
        mem_wdata  = wdata_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    if_rvalid_d = (state_q == IF_ACC);
    if_rdata_d  = (state_q == IF_ACC) ? mem_rdata : '0;
    d_rvalid_d  = (state_q == D_ACC);
    d_rdata_d   = ((state_q == D_ACC) && !we_q) ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait_q, perf_if_wait_d;
  logic [31:0] perf_d_grants_q, perf_d_grants_d;

  always_comb begin
    perf_if_wait_d  = perf_if_wait_q;
    perf_d_grants_d = perf_d_grants_q;
    if (if_req && !if_gnt) perf_if_wait_d  = perf_if_wait_q + 32'd1;
    if (d_gnt)             perf_d_grants_d = perf_d_grants_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_wait_q  <= '0;
      perf_d_grants_q <= '0;
    end else begin
      perf_if_wait_q  <= perf_if_wait_d;
      perf_d_grants_q <= perf_d_grants_d;
    end
  end

  assign perf_if_wait  = perf_if_wait_q;
  assign perf_d_grants = perf_d_grants_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level reference model.
module tb_unified_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned MAX_STREAK = 4;
  localparam int unsigned DBASE      = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait, perf_d_grants;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] tb_mem  [0:511];
  logic [31:0] ref_mem [0:511];

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W(8), .DATA_BASE(DBASE), .MAX_D_STREAK(MAX_STREAK)
  ) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_wait(perf_if_wait), .perf_d_grants(perf_d_grants)
`endif
  );

  // Word-per-address memory stub with combinational read.
  assign mem_rdata = tb_mem[mem_addr[8:0]];
  always @(posedge clk) if (mem_write) tb_mem[mem_addr[8:0]] <= mem_wdata;

  initial begin
    for (int i = 0; i < 512; i++) begin
      tb_mem[i]  <= 32'h5A00_0000 | 32'(i);
      ref_mem[i]  = 32'h5A00_0000 | 32'(i);
    end
  end

  assert property (@(posedge clk) disable iff (!rst) (if_req && !if_gnt) |=> if_req)
    else begin errors++; $display("FAIL if_req_protocol: dropped without grant"); end
  assert property (@(posedge clk) disable iff (!rst) (d_req && !d_gnt) |=> d_req)
    else begin errors++; $display("FAIL d_req_protocol: dropped without grant"); end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [203:0] outs;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc_start(); #2;
      outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
              mem_read, mem_write, mem_funct3, mem_addr, mem_wdata, 32'd0};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h want 0", k, outs);
      end
    end
`ifdef MEM_ARB_PERF_EN
    checks++;
    if ({perf_if_wait, perf_d_grants} !== 64'd0) begin
      errors++;
      $display("FAIL reset_perf: got %h/%h want 0/0", perf_if_wait, perf_d_grants);
    end
`endif
  endtask

  task automatic test_fetch();
    cyc_start(); if_req = 1'b1; if_addr = 32'h104; #2;
    checks++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      errors++; $display("FAIL fetch_gnt: got %b want 10", {if_gnt, d_gnt});
    end
    cyc_start(); if_req = 1'b0; #2;
    checks++;
    if ({mem_read, mem_write, mem_funct3, mem_addr} !== {1'b1, 1'b0, 3'b010, 32'h4}) begin
      errors++;
      $display("FAIL fetch_mem: got rd=%b wr=%b f3=%b addr=%h want 1 0 010 00000004",
               mem_read, mem_write, mem_funct3, mem_addr);
    end
    cyc_start(); #2;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, ref_mem[4]}) begin
      errors++;
      $display("FAIL fetch_rdata: got v=%b %h want 1 %h", if_rvalid, if_rdata, ref_mem[4]);
    end
    cyc_start(); #2;
    checks++;
    if (if_rvalid !== 1'b0) begin
      errors++; $display("FAIL fetch_rvalid_pulse: got %b want 0", if_rvalid);
    end
  endtask

  task automatic test_store_load();
    cyc_start();
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
    #2;
    checks++;
    if (d_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt: got %b want 1", d_gnt); end
    cyc_start(); d_req = 1'b0; #2;
    checks++;
    if ({mem_write, mem_read, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'd208, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL store_mem: got wr=%b rd=%b addr=%0d wd=%h want 1 0 208 deadbeef",
               mem_write, mem_read, mem_addr, mem_wdata);
    end
    ref_mem[208] = 32'hDEADBEEF;
    cyc_start(); d_req = 1'b1; d_we = 1'b0; d_wdata = '0; #2;
    checks++;
    if ({mem_write, d_rvalid, d_rdata, d_gnt} !== {1'b0, 1'b1, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL store_done: got wr=%b v=%b rd=%h gnt=%b want 0 1 0 1",
               mem_write, d_rvalid, d_rdata, d_gnt);
    end
    cyc_start(); d_req = 1'b0; #2;
    checks++;
    if ({mem_read, mem_addr, d_rvalid} !== {1'b1, 32'd208, 1'b0}) begin
      errors++;
      $display("FAIL load_mem: got rd=%b addr=%0d v=%b want 1 208 0", mem_read, mem_addr, d_rvalid);
    end
    cyc_start(); #2;
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL load_rdata: got v=%b %h want 1 deadbeef", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_streak();
    logic exp_d;
    do_reset();
    if_addr = 32'h10; d_addr = 32'h20; d_we = 1'b0; d_funct3 = 3'b010;
    for (int k = 0; k < 15; k++) begin
      cyc_start(); if_req = 1'b1; d_req = 1'b1; #2;
      exp_d = (k % 5) < 4;
      checks++;
      if ({if_gnt, d_gnt} !== {!exp_d, exp_d}) begin
        errors++;
        $display("FAIL streak_pattern k=%0d: got if/d=%b want %b", k, {if_gnt, d_gnt}, {!exp_d, exp_d});
      end
    end
    cyc_start(); if_req = 1'b0; #2;
    checks++;
    if (d_gnt !== 1'b1) begin errors++; $display("FAIL streak_tail: got %b want 1", d_gnt); end
`ifdef MEM_ARB_PERF_EN
    checks++;
    if ({perf_if_wait, perf_d_grants} !== {32'd12, 32'd12}) begin
      errors++;
      $display("FAIL perf_counts: got wait=%0d dg=%0d want 12 12", perf_if_wait, perf_d_grants);
    end
`endif
    cyc_start(); d_req = 1'b0; #2;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc_start();
    if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; #2;
    checks++;
    if (d_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt0: got %b want 1", d_gnt); end
    cyc_start(); d_addr = 32'h24; #2;
    checks++;
    if (d_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt1: got %b want 1", d_gnt); end
    cyc_start(); #1;
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL rmid_pre: got rd=%b want 1", mem_read); end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; #1;
    checks++;
    if ({mem_read, mem_write} !== 2'b00) begin
      errors++; $display("FAIL rmid_async: got rd/wr=%b want 00", {mem_read, mem_write});
    end
    cyc_start(); #2;
    checks++;
    if ({d_rvalid, d_rdata, if_rvalid, if_gnt, d_gnt, mem_read, mem_write, mem_addr} !== '0) begin
      errors++;
      $display("FAIL rmid_outs: got dv=%b dr=%h iv=%b ig=%b dg=%b rd=%b wr=%b addr=%h want all 0",
               d_rvalid, d_rdata, if_rvalid, if_gnt, d_gnt, mem_read, mem_write, mem_addr);
    end
    cyc_start(); rst = 1'b1; #2;
    checks++;
    if ({u_dut.state_q == IDLE, u_dut.u_streak.streak_q, d_rvalid} !== {1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_release: got state=%0d streak=%0d dv=%b want 0 0 0",
               u_dut.state_q, u_dut.u_streak.streak_q, d_rvalid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc_start();
      if (k < 3) begin if_req = 1'b1; if_addr = 32'(4 * k); end
      else if_req = 1'b0;
      #2;
      if (k < 3) begin
        checks++;
        if (if_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt k=%0d: got %b want 1", k, if_gnt); end
      end
      checks++;
      if (k >= 2 && k < 5) begin
        if ({if_rvalid, if_rdata} !== {1'b1, ref_mem[4 * (k - 2)]}) begin
          errors++;
          $display("FAIL b2b_rdata k=%0d: got v=%b %h want 1 %h", k, if_rvalid, if_rdata, ref_mem[4 * (k - 2)]);
        end
      end else if (if_rvalid !== 1'b0) begin
        errors++; $display("FAIL b2b_idle k=%0d: got v=%b want 0", k, if_rvalid);
      end
    end
  endtask

  // Transaction-level model: grant rule from request state and a count of
  // consecutive data wins; accesses applied to ref_mem in grant order.
  task automatic test_random();
    localparam int N = 400;
    int          streak_m;
    logic        ig_prev, dg_prev, exp_ig, exp_dg;
    logic        ev_if_v [4], ev_d_v [4], em_r [4], em_w [4];
    logic [31:0] ev_if_d [4], ev_d_d [4], em_a [4], em_wd [4];
    logic [2:0]  em_f [4];
    int unsigned s0, s1, s2;
    logic [31:0] ea;
    do_reset();
    streak_m = 0; ig_prev = 1'b0; dg_prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ev_if_v[i] = 1'b0; ev_d_v[i] = 1'b0; em_r[i] = 1'b0; em_w[i] = 1'b0;
      ev_if_d[i] = '0; ev_d_d[i] = '0; em_a[i] = '0; em_wd[i] = '0; em_f[i] = '0;
    end
    for (int t = 0; t < N + 30; t++) begin
      cyc_start();
      if (ig_prev) if_req = 1'b0;
      if (dg_prev) d_req = 1'b0;
      if (t < N) begin
        if (!if_req && $urandom_range(0, 3) != 0) begin
          if_req = 1'b1; if_addr = $urandom;
        end
        if (!d_req && $urandom_range(0, 2) != 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_funct3 = 3'($urandom_range(0, 7));
          d_addr = $urandom; d_wdata = $urandom;
        end
      end
      #2;
      s0 = t % 4; s1 = (t + 1) % 4; s2 = (t + 2) % 4;
      exp_dg = d_req && (!if_req || streak_m < int'(MAX_STREAK));
      exp_ig = if_req && !exp_dg;
      checks++;
      if ({if_gnt, d_gnt} !== {exp_ig, exp_dg}) begin
        errors++; $display("FAIL rnd_gnt t=%0d: got if/d=%b want %b", t, {if_gnt, d_gnt}, {exp_ig, exp_dg});
      end
      checks++;
      if ({mem_read, mem_write, mem_addr, mem_funct3} !== {em_r[s0], em_w[s0], em_a[s0], em_f[s0]}
          || (em_w[s0] && mem_wdata !== em_wd[s0])) begin
        errors++;
        $display("FAIL rnd_mem t=%0d: got rd=%b wr=%b addr=%h f3=%b wd=%h want %b %b %h %b %h", t,
                 mem_read, mem_write, mem_addr, mem_funct3, mem_wdata,
                 em_r[s0], em_w[s0], em_a[s0], em_f[s0], em_wd[s0]);
      end
      checks++;
      if (if_rvalid !== ev_if_v[s0] || (ev_if_v[s0] && if_rdata !== ev_if_d[s0])) begin
        errors++;
        $display("FAIL rnd_if_resp t=%0d: got v=%b %h want %b %h", t, if_rvalid, if_rdata, ev_if_v[s0], ev_if_d[s0]);
      end
      checks++;
      if (d_rvalid !== ev_d_v[s0] || (ev_d_v[s0] && d_rdata !== ev_d_d[s0])) begin
        errors++;
        $display("FAIL rnd_d_resp t=%0d: got v=%b %h want %b %h", t, d_rvalid, d_rdata, ev_d_v[s0], ev_d_d[s0]);
      end
      em_r[s0] = 1'b0; em_w[s0] = 1'b0; em_a[s0] = '0; em_f[s0] = '0; em_wd[s0] = '0;
      ev_if_v[s0] = 1'b0; ev_d_v[s0] = 1'b0;
      if (exp_ig) begin
        ea = if_addr & 32'hFF;
        em_r[s1] = 1'b1; em_a[s1] = ea; em_f[s1] = 3'b010;
        ev_if_v[s2] = 1'b1; ev_if_d[s2] = ref_mem[ea[8:0]];
      end else if (exp_dg) begin
        ea = (d_addr & 32'hFF) + DBASE;
        em_r[s1] = !d_we; em_w[s1] = d_we; em_a[s1] = ea; em_f[s1] = d_funct3;
        em_wd[s1] = d_wdata;
        ev_d_v[s2] = 1'b1;
        if (d_we) begin
          ref_mem[ea[8:0]] = d_wdata;
          ev_d_d[s2] = '0;
        end else begin
          ev_d_d[s2] = ref_mem[ea[8:0]];
        end
      end
      if (!if_req || exp_ig) streak_m = 0;
      else if (exp_dg && streak_m < int'(MAX_STREAK)) streak_m++;
      ig_prev = exp_ig; dg_prev = exp_dg;
    end
    checks++;
    if ({if_req, d_req} !== 2'b00) begin
      errors++; $display("FAIL rnd_drain: requests still pending if/d=%b want 00", {if_req, d_req});
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_fetch();
    test_store_load();
    test_streak();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
